// File: rtl/huff_pkg.sv
// Shared constants, leaf record and sorter state encoding for the Huffman leaf sorter.
package huff_pkg;

  localparam int SYM_W   = 8;
  localparam int FREQ_W  = 24;
  localparam int NUM_SYM = 1 << SYM_W;

  typedef struct packed {
    logic [SYM_W-1:0]  symbol;
    logic [FREQ_W-1:0] freq;
    logic              valid;
  } leaf_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } sorter_state_t;

  function automatic leaf_t make_leaf(input logic [SYM_W-1:0] symbol, input logic [FREQ_W-1:0] freq);
    make_leaf = {symbol, freq, 1'b1};
  endfunction

endpackage

// File: rtl/huff_leaf_sorter_if.sv
// Leaf stream from the sorter to the tree/codebook builder (valid/ready).
interface huff_leaf_sorter_if;
  import huff_pkg::*;

  logic              out_valid;
  logic              out_ready;
  logic [SYM_W-1:0]  out_symbol;
  logic [FREQ_W-1:0] out_freq;

  modport master (output out_valid, output out_symbol, output out_freq, input out_ready);
  modport slave  (input out_valid, input out_symbol, input out_freq, output out_ready);

endinterface

// File: rtl/huff_leaf_array.sv
// Ascending-frequency insertion array: single-cycle sorted insert or head pop.
module huff_leaf_array
  import huff_pkg::*;
#(
  parameter int DEPTH = NUM_SYM
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             ins_en,
  input  leaf_t            ins_leaf,
  input  logic             pop,
  output leaf_t            head,
  output logic             full,
  output logic [SYM_W:0]   count,
  output logic             drop_flag
);

  leaf_t            arr_r       [DEPTH];
  leaf_t            nxt_s       [DEPTH];
  leaf_t            shift_src_s [DEPTH];
  leaf_t            pop_src_s   [DEPTH];
  logic [DEPTH-1:0] before_s;
  logic [SYM_W:0]   count_r;
  logic             full_s;

  // before_s is monotone (valid entries form a sorted prefix), so its first set bit is the insert slot.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
    assign before_s[gi] = !arr_r[gi].valid || (arr_r[gi].freq > ins_leaf.freq);
    if (gi == 0) begin : g_first
      assign shift_src_s[gi] = ins_leaf;
    end else begin : g_rest
      assign shift_src_s[gi] = before_s[gi-1] ? arr_r[gi-1] : ins_leaf;
    end
    if (gi == DEPTH - 1) begin : g_tail
      assign pop_src_s[gi] = '0;
    end else begin : g_body
      assign pop_src_s[gi] = arr_r[gi+1];
    end
    assign nxt_s[gi] = clr    ? leaf_t'('0) :
                       ins_en ? (before_s[gi] ? shift_src_s[gi] : arr_r[gi]) :
                       pop    ? pop_src_s[gi] : arr_r[gi];
  end

  // Entry storage
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      arr_r <= '{default: '0};
    end else begin
      arr_r <= nxt_s;
    end
  end

  // Valid-entry count, saturating at DEPTH because a full insert swaps rather than grows
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_r <= '0;
    end else if (clr) begin
      count_r <= '0;
    end else if (ins_en && !full_s) begin
      count_r <= count_r + (SYM_W+1)'(1);
    end else if (pop && (count_r != '0)) begin
      count_r <= count_r - (SYM_W+1)'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign full_s    = (count_r == (SYM_W+1)'(DEPTH));
  assign full      = full_s;
  assign count     = count_r;
  assign head      = arr_r[0];
  assign drop_flag = ins_en && full_s;

endmodule

// File: rtl/huff_leaf_sorter.sv
// Scans the frequency table, sorts non-zero entries into leaves and streams them out.
// Optional HUFF_SINGLE_LEAF_PAD_EN: a lone leaf gets a zero-frequency partner (symbol ^ 1).
module huff_leaf_sorter
  import huff_pkg::*;
#(
  parameter int DEPTH = NUM_SYM
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [SYM_W-1:0]   rd_addr,
  input  logic [FREQ_W-1:0]  rd_freq,
  output logic [SYM_W:0]     leaf_count,
  output logic               overflow,
  huff_leaf_sorter_if.master leaf_out
);

`ifdef HUFF_SINGLE_LEAF_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  sorter_state_t    state_r;
  logic [SYM_W-1:0] rd_addr_r;
  logic [SYM_W:0]   leaf_count_r;
  logic             busy_r, done_r, out_valid_r, overflow_r, pad_r;

  leaf_t            head_s, ins_leaf_s;
  logic             full_s, drop_s, clr_s, ins_en_s, pop_s;
  logic [SYM_W:0]   count_s, count_after_s;

  huff_leaf_array #(.DEPTH(DEPTH)) u_array (
    .clk       (clk),
    .reset_n   (reset_n),
    .clr       (clr_s),
    .ins_en    (ins_en_s),
    .ins_leaf  (ins_leaf_s),
    .pop       (pop_s),
    .head      (head_s),
    .full      (full_s),
    .count     (count_s),
    .drop_flag (drop_s)
  );

  // Array control: clear on start, insert while scanning or padding, pop on handshake
  always_comb begin
    clr_s      = 1'b0;
    ins_en_s   = 1'b0;
    pop_s      = 1'b0;
    ins_leaf_s = make_leaf(rd_addr_r, rd_freq);
    case (state_r)
      IDLE:  clr_s    = start;
      SCAN:  ins_en_s = (rd_freq != {FREQ_W{1'b0}});
      DRAIN: begin
        if (pad_r) begin
          ins_en_s   = 1'b1;
          ins_leaf_s = make_leaf(head_s.symbol ^ SYM_W'(1), {FREQ_W{1'b0}});
        end else begin
          pop_s = out_valid_r && leaf_out.out_ready;
        end
      end
      default: clr_s = 1'b0;
    endcase
  end

  assign count_after_s = count_s + {{SYM_W{1'b0}}, (ins_en_s && !full_s)};

  // Sequencer: IDLE -> SCAN (one address per cycle) -> DRAIN -> IDLE
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= IDLE;
      rd_addr_r    <= '0;
      leaf_count_r <= '0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      out_valid_r  <= 1'b0;
      overflow_r   <= 1'b0;
      pad_r        <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r      <= SCAN;
            rd_addr_r    <= '0;
            leaf_count_r <= '0;
            overflow_r   <= 1'b0;
            busy_r       <= 1'b1;
            out_valid_r  <= 1'b0;
          end
        end
        SCAN: begin
          rd_addr_r <= rd_addr_r + SYM_W'(1);
          if (rd_addr_r == {SYM_W{1'b1}}) begin
            state_r <= DRAIN;
            // Pad insertion takes the first DRAIN cycle, so the stream starts one cycle later
            if (PAD_EN && (count_after_s == (SYM_W+1)'(1))) begin
              pad_r        <= 1'b1;
              leaf_count_r <= (SYM_W+1)'(2);
              out_valid_r  <= 1'b0;
            end else begin
              leaf_count_r <= count_after_s;
              out_valid_r  <= (count_after_s != '0);
            end
          end
        end
        DRAIN: begin
          if (pad_r) begin
            pad_r       <= 1'b0;
            out_valid_r <= 1'b1;
          end else if (out_valid_r) begin
            if (leaf_out.out_ready && (count_s == (SYM_W+1)'(1))) begin
              out_valid_r <= 1'b0;
              done_r      <= 1'b1;
              busy_r      <= 1'b0;
              state_r     <= IDLE;
            end
          end else if (!head_s.valid) begin
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end else begin
            out_valid_r <= 1'b1;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign busy                = busy_r;
  assign done                = done_r;
  assign rd_addr             = rd_addr_r;
  assign leaf_count          = leaf_count_r;
  assign overflow            = overflow_r;
  assign leaf_out.out_valid  = out_valid_r;
  assign leaf_out.out_symbol = head_s.symbol;
  assign leaf_out.out_freq   = head_s.freq;

endmodule

// File: tb/tb_huff_leaf_sorter.sv
// Self-checking bench: directed vector table plus randomized tables against a sort-based model.
module tb_huff_leaf_sorter;
  import huff_pkg::*;

  logic clk, reset_n, start, out_ready;
  logic busy, done, overflow, busy4, done4, overflow4;
  logic [SYM_W-1:0]  rd_addr, rd_addr4;
  logic [FREQ_W-1:0] rd_freq, rd_freq4;
  logic [SYM_W:0]    leaf_count, leaf_count4;
  logic [FREQ_W-1:0] tbl [NUM_SYM];

  huff_leaf_sorter_if lif ();
  huff_leaf_sorter_if lif4 ();

  assign rd_freq        = tbl[rd_addr];
  assign rd_freq4       = tbl[rd_addr4];
  assign lif.out_ready  = out_ready;
  assign lif4.out_ready = out_ready;

  huff_leaf_sorter dut (
    .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
    .rd_addr(rd_addr), .rd_freq(rd_freq), .leaf_count(leaf_count),
    .overflow(overflow), .leaf_out(lif)
  );

  huff_leaf_sorter #(.DEPTH(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .start(start), .busy(busy4), .done(done4),
    .rd_addr(rd_addr4), .rd_freq(rd_freq4), .leaf_count(leaf_count4),
    .overflow(overflow4), .leaf_out(lif4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int              n_in;
    logic [0:7][31:0] in_leaf;
    int              pct;
    int              exp_n;
    logic [0:7][31:0] exp_leaf;
    int              exp4_n;
    logic [0:3][31:0] exp4_leaf;
    bit              exp4_ovf;
  } vec_t;

  vec_t        vecs [6];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q [$];
  logic [31:0] exp4_q [$];
  bit          exp4_ovf;

  function automatic logic [31:0] lf(input int sym, input int freq);
    logic [7:0]  s = sym[7:0];
    logic [23:0] f = freq[23:0];
    return {s, f};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", nm, act, req);
    end
  endtask

  task automatic load_vec(input int v);
    for (int s = 0; s < NUM_SYM; s++) tbl[s] = 24'd0;
    for (int i = 0; i < vecs[v].n_in; i++) begin
      logic [31:0] e = vecs[v].in_leaf[i];
      if (e[23:0] != 24'd0) tbl[e[31:24]] = e[23:0];
    end
    exp_q.delete();
    exp4_q.delete();
    for (int i = 0; i < vecs[v].exp_n; i++) exp_q.push_back(vecs[v].exp_leaf[i]);
    for (int i = 0; i < vecs[v].exp4_n; i++) exp4_q.push_back(vecs[v].exp4_leaf[i]);
    exp4_ovf = vecs[v].exp4_ovf;
  endtask

  // Reference: sort by (freq, symbol) key, keep the DEPTH smallest, pad a lone leaf.
  task automatic model_from_tbl();
    logic [31:0] keys [$];
    exp_q.delete();
    exp4_q.delete();
    for (int s = 0; s < NUM_SYM; s++)
      if (tbl[s] != 24'd0) keys.push_back({tbl[s], s[7:0]});
    keys.sort();
    foreach (keys[i]) begin
      exp_q.push_back({keys[i][7:0], keys[i][31:8]});
      if (i < 4) exp4_q.push_back({keys[i][7:0], keys[i][31:8]});
    end
    exp4_ovf = (keys.size() > 4);
`ifdef HUFF_SINGLE_LEAF_PAD_EN
    if (keys.size() == 1) begin
      exp_q.push_front({keys[0][7:0] ^ 8'h01, 24'd0});
      exp4_q.push_front({keys[0][7:0] ^ 8'h01, 24'd0});
    end
`endif
  endtask

  task automatic run_case(input string tag, input int pct);
    int          cyc = 1;
    int          first_cyc = -1, last_acc = -1, done_cyc = -1, done4_cyc = -1;
    int          busy_bad = 0, hold_bad = 0;
    bit          stall_prev = 1'b0;
    logic [31:0] prev_leaf = '0, cur;
    logic [31:0] got_q [$];
    logic [31:0] got4_q [$];
    bit          pad_exp = (exp_q.size() > 0) && (exp_q[0][23:0] == 24'd0);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk({tag, "_busy_start"}, busy, 1);
    chk({tag, "_ovf_cleared"}, overflow, 0);
    chk({tag, "_ovf4_cleared"}, overflow4, 0);
    while ((done_cyc < 0 || done4_cyc < 0) && cyc < 3000) begin
      out_ready = ($urandom_range(0, 99) < pct);
      cur = {lif.out_symbol, lif.out_freq};
      if (cyc <= 256 && busy !== 1'b1) busy_bad++;
      if (stall_prev && (!lif.out_valid || cur !== prev_leaf)) hold_bad++;
      stall_prev = lif.out_valid && !out_ready;
      prev_leaf  = cur;
      if (lif.out_valid) begin
        if (first_cyc < 0) first_cyc = cyc;
        if (out_ready) begin
          got_q.push_back(cur);
          last_acc = cyc;
        end
      end
      if (lif4.out_valid && out_ready) got4_q.push_back({lif4.out_symbol, lif4.out_freq});
      if (done && done_cyc < 0) begin
        done_cyc = cyc;
        chk({tag, "_busy_at_done"}, busy, 0);
      end
      if (done4 && done4_cyc < 0) done4_cyc = cyc;
      if (cyc == 257) chk({tag, "_leaf_count_drain"}, leaf_count, exp_q.size());
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_done_seen"}, (done_cyc >= 0 && done4_cyc >= 0), 1);
    chk({tag, "_busy_scan"}, busy_bad, 0);
    chk({tag, "_hold"}, hold_bad, 0);
    if (exp_q.size() == 0) begin
      chk({tag, "_no_valid"}, (first_cyc < 0), 1);
      chk({tag, "_done_cycle"}, done_cyc, 258);
    end else begin
      chk({tag, "_latency"}, first_cyc, pad_exp ? 258 : 257);
      chk({tag, "_done_cycle"}, done_cyc, last_acc + 1);
    end
    chk({tag, "_n_leaves"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s_leaf%0d", tag, i), got_q[i], exp_q[i]);
    chk({tag, "_n_leaves4"}, got4_q.size(), exp4_q.size());
    for (int i = 0; i < exp4_q.size() && i < got4_q.size(); i++)
      chk($sformatf("%s_leaf4_%0d", tag, i), got4_q[i], exp4_q[i]);
    chk({tag, "_leaf_count"}, leaf_count, exp_q.size());
    chk({tag, "_leaf_count4"}, leaf_count4, exp4_q.size());
    chk({tag, "_overflow"}, overflow, 0);
    chk({tag, "_overflow4"}, overflow4, exp4_ovf);
  endtask

  initial begin
    int dens_tab [6] = '{1, 3, 10, 50, 100, 2};

    vecs[0].n_in = 7;
    vecs[0].in_leaf = {lf(0, 405), lf(1, 41), lf(2, 22), lf(3, 14), lf(4, 15), lf(5, 8), lf(6, 1), 32'd0};
    vecs[0].pct = 100;
    vecs[0].exp_n = 7;
    vecs[0].exp_leaf = {lf(6, 1), lf(5, 8), lf(3, 14), lf(4, 15), lf(2, 22), lf(1, 41), lf(0, 405), 32'd0};
    vecs[0].exp4_n = 4;
    vecs[0].exp4_leaf = {lf(6, 1), lf(5, 8), lf(3, 14), lf(4, 15)};
    vecs[0].exp4_ovf = 1'b1;

    vecs[1] = vecs[0];
    vecs[1].pct = 30;

    vecs[2].n_in = 6;
    vecs[2].in_leaf = {lf(0, 9), lf(1, 7), lf(2, 5), lf(3, 3), lf(4, 1), lf(5, 2), 32'd0, 32'd0};
    vecs[2].pct = 100;
    vecs[2].exp_n = 6;
    vecs[2].exp_leaf = {lf(4, 1), lf(5, 2), lf(3, 3), lf(2, 5), lf(1, 7), lf(0, 9), 32'd0, 32'd0};
    vecs[2].exp4_n = 4;
    vecs[2].exp4_leaf = {lf(4, 1), lf(5, 2), lf(3, 3), lf(2, 5)};
    vecs[2].exp4_ovf = 1'b1;

    vecs[3].n_in = 3;
    vecs[3].in_leaf = {lf(200, 5), lf(10, 5), lf(3, 5), 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    vecs[3].pct = 100;
    vecs[3].exp_n = 3;
    vecs[3].exp_leaf = {lf(3, 5), lf(10, 5), lf(200, 5), 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    vecs[3].exp4_n = 3;
    vecs[3].exp4_leaf = {lf(3, 5), lf(10, 5), lf(200, 5), 32'd0};
    vecs[3].exp4_ovf = 1'b0;

    vecs[4].n_in = 0;
    vecs[4].in_leaf = '0;
    vecs[4].pct = 100;
    vecs[4].exp_n = 0;
    vecs[4].exp_leaf = '0;
    vecs[4].exp4_n = 0;
    vecs[4].exp4_leaf = '0;
    vecs[4].exp4_ovf = 1'b0;

    vecs[5].n_in = 1;
    vecs[5].in_leaf = {lf(8'h42, 7), 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    vecs[5].pct = 100;
    vecs[5].exp4_ovf = 1'b0;
`ifdef HUFF_SINGLE_LEAF_PAD_EN
    vecs[5].exp_n = 2;
    vecs[5].exp_leaf = {lf(8'h43, 0), lf(8'h42, 7), 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    vecs[5].exp4_n = 2;
    vecs[5].exp4_leaf = {lf(8'h43, 0), lf(8'h42, 7), 32'd0, 32'd0};
`else
    vecs[5].exp_n = 1;
    vecs[5].exp_leaf = {lf(8'h42, 7), 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    vecs[5].exp4_n = 1;
    vecs[5].exp4_leaf = {lf(8'h42, 7), 32'd0, 32'd0, 32'd0};
`endif

    reset_n = 1'b0;
    start = 1'b0;
    out_ready = 1'b0;
    for (int s = 0; s < NUM_SYM; s++) tbl[s] = 24'd0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", lif.out_valid, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_leaf_count", leaf_count, 0);
    chk("rst_overflow", overflow, 0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      load_vec(v);
      run_case($sformatf("vec%0d", v), vecs[v].pct);
    end

    // Reset in the middle of a scan, then a clean rerun
    load_vec(0);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (99) @(negedge clk);
    chk("midrst_busy_before", busy, 1);
    chk("midrst_addr_before", rd_addr, 99);
    reset_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_valid", lif.out_valid, 0);
    chk("midrst_rd_addr", rd_addr, 0);
    chk("midrst_leaf_count", leaf_count, 0);
    chk("midrst_busy4", busy4, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    run_case("after_rst", 100);

    for (int r = 0; r < 6; r++) begin
      for (int s = 0; s < NUM_SYM; s++) begin
        if ($urandom_range(0, 99) < dens_tab[r])
          tbl[s] = r[0] ? 24'($urandom_range(1, 12)) : 24'($urandom_range(1, 24'hFFFFFF));
        else
          tbl[s] = 24'd0;
      end
      model_from_tbl();
      run_case($sformatf("rnd%0d", r), $urandom_range(30, 100));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
